light_sequencer_multi: RTL and testbench
========================================

// Module: light_sequencer_multi
// PURPOSE
//  Multi-channel, parametrised successor to the single-channel lights selector.
//  Each of NCH channels keeps its own colour index (1..NSTATES) and advances it in one of four modes.
//  Indices pass through a pipelined colour LUT; a shared sel mux then forces white.
//  Feeds the RGB LED driver; one 3*CW-bit RGB word per channel.
// PARAMETERS
//  NCH      4   number of independent light channels
//  CW       8   bits per colour component; one channel word = 3*CW bits {R,G,B}
//  NSTATES  6   sequence length; legal range 2..6; indices run 1..NSTATES
//  LUT_LAT  2   LUT pipeline depth in cycles, >=1
//  PRESC_W  16  width of the auto-mode prescaler
// PORTS
//  clk     in   1             system clock, rising edge
//  rst     in   1             synchronous, active-high reset
//  sel     in   1             1 = sequenced colour, 0 = force white on all channels
//  mode    in   2             00 HOLD_RUN, 01 AUTO, 10 STEP, 11 FREEZE
//  button  in   NCH           per-channel advance request
//  presc   in   PRESC_W       AUTO tick period minus 1
//  light   out  NCH*3*CW      channel i at [i*3*CW +: 3*CW]
//  wrap    out  NCH           1-cycle pulse when channel i wraps NSTATES->1
// BEHAVIOUR
//  Reset (rst=1 at a clk edge; overrides all other inputs):
//   - every idx=1; prescaler=0; wrap=0; button edge regs=0
//   - all LUT pipeline stages load colour(1) = BLUE {0,0,1s}
//   - so light = BLUE per channel (sel=1), or all-ones (sel=0), from the cycle after the reset edge.
//  Index advance, per channel, evaluated every edge with rst=0:
//   - HOLD_RUN: advance every cycle while button[i]=1.
//   - AUTO: advance all channels on the prescaler tick; button is ignored.
//   - STEP: advance once per rising edge of button[i], i.e. button=1 and prev=0.
//   - FREEZE: hold.
//   - advance: idx==NSTATES -> idx=1 and wrap[i]=1 (same edge), else idx+1 and wrap[i]=0.
//   - idx never takes 0 or a value >NSTATES.
//  Prescaler:
//   - counts 0..presc only in AUTO; tick when count==presc, then count->0.
//   - presc=0 ticks every cycle.
//   - count is cleared whenever mode!=AUTO; presc changes apply on the next compare.
//  Edge register: updates every cycle in every mode, so entering STEP with button held gives no advance.
//  Colour map: idx bit2->R, bit1->G, bit0->B; each set bit drives the full component to all-ones.
//   - 1 BLUE, 2 GREEN, 3 CYAN, 4 RED, 5 MAGENTA, 6 YELLOW.
//  Latency:
//   - idx register changes at edge N; light reflects it after edge N+LUT_LAT.
//   - wrap is NOT delayed: it is aligned to the idx change.
//  sel mux:
//   - combinational, after the LUT; sel=0 -> light = all ones, immediately and independent of rst/mode.
//   - sequencing continues underneath while sel=0.
//  Mode change: takes effect at the first edge it is sampled; no pipeline flush.
// STRUCTURE
//  light_seq_pkg:
//   - mode enum (HOLD_RUN/AUTO/STEP/FREEZE)
//   - colour index constants
//   - function idx_to_rgb(idx, CW)
//   - WHITE/BLUE builders
//  Sub-module colour_lut (idx in, LUT_LAT-deep registered RGB out, sync reset to BLUE):
//   - one instance per channel via generate.
//  Top holds the prescaler, per-channel index/edge/wrap regs and the sel mux.
// TESTING (NCH=2, CW=8, NSTATES=6, LUT_LAT=2, CLK 10ns)
//  1. rst=1 for 3 clk, sel=1 -> light=0x0000FF_0000FF, wrap=00; drop rst with button=00 for 5 clk -> unchanged.
//  2. HOLD_RUN, button=01 held 6 clk:
//     - ch0 light steps 00FF00,00FFFF,FF0000,FF00FF,FFFF00,0000FF, two cycles after each idx edge.
//     - wrap[0] pulses once on the 6->1 edge; ch1 stays 0000FF.
//  3. STEP, button[1] high 4 clk then low -> ch1 advances exactly once to 00FF00.
//     - entering STEP with button already high -> no advance.
//  4. AUTO, presc=3, button=11 -> both channels advance every 4th clk.
//     - presc=0 -> every clk; FREEZE -> hold, prescaler cleared.
//  5. sel=0 during AUTO -> light=all-ones the same cycle.
//     - sel=1 after 5 ticks -> shows advanced colours, not frozen ones.
//  6. rst=1 mid-sequence with sel=0 -> still all-ones.
//     - then sel=1 -> 0x0000FF_0000FF; rst during a wrap edge -> wrap stays 0.

Source files
------------

// File: rtl/light_sequencer_multi_pkg.sv
// Shared types and helpers for the multi-channel light sequencer.
//   mode_e        : advance mode (HOLD_RUN/AUTO/STEP/FREEZE)
//   IDX_*         : colour index constants (1..6)
//   idx_to_rgb    : index -> {R,G,B} word, each component CW bits wide
//   white_word / blue_word : fixed colour words
package light_seq_pkg;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned MAX_CW = 32;

  typedef logic [3*MAX_CW-1:0] word_t;

  typedef enum logic [1:0] {
    HOLD_RUN = 2'b00,
    AUTO     = 2'b01,
    STEP     = 2'b10,
    FREEZE   = 2'b11
  } mode_e;

  localparam logic [IDX_W-1:0] IDX_BLUE    = 3'd1;
  localparam logic [IDX_W-1:0] IDX_GREEN   = 3'd2;
  localparam logic [IDX_W-1:0] IDX_CYAN    = 3'd3;
  localparam logic [IDX_W-1:0] IDX_RED     = 3'd4;
  localparam logic [IDX_W-1:0] IDX_MAGENTA = 3'd5;
  localparam logic [IDX_W-1:0] IDX_YELLOW  = 3'd6;

  // idx bit2 -> R, bit1 -> G, bit0 -> B; a set bit saturates the component.
  // Result is right-aligned in word_t; callers size-cast to 3*cw bits.
  function automatic word_t idx_to_rgb(input logic [IDX_W-1:0] idx,
                                       input int unsigned cw);
    word_t ones;
    word_t rgb;
    ones = ~(word_t'('1) << cw);
    rgb  = '0;
    if (idx[2]) rgb = rgb | (ones << (2 * cw));
    if (idx[1]) rgb = rgb | (ones << cw);
    if (idx[0]) rgb = rgb | ones;
    return rgb;
  endfunction

  function automatic word_t white_word(input int unsigned cw);
    return idx_to_rgb(3'd7, cw);
  endfunction

  function automatic word_t blue_word(input int unsigned cw);
    return idx_to_rgb(IDX_BLUE, cw);
  endfunction

endpackage

// File: rtl/light_sequencer_multi_if.sv
// Control/data bundle between the sequencer and its controller.
//   sel    : 1 = sequenced colour, 0 = force white
//   mode   : advance mode (see light_seq_pkg::mode_e)
//   button : per-channel advance request
//   presc  : AUTO tick period minus 1
//   light  : NCH RGB words, channel i at [i*3*CW +: 3*CW]
//   wrap   : per-channel 1-cycle wrap pulse
interface light_sequencer_multi_if #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 8,
  parameter int unsigned PRESC_W = 16
);
  logic                  sel;
  logic [1:0]            mode;
  logic [NCH-1:0]        button;
  logic [PRESC_W-1:0]    presc;
  logic [NCH*3*CW-1:0]   light;
  logic [NCH-1:0]        wrap;

  modport master (output sel, mode, button, presc, input light, wrap);
  modport slave  (input sel, mode, button, presc, output light, wrap);
endinterface

// File: rtl/light_sequencer_multi_colour_lut.sv
// Pipelined colour lookup for one channel.
//   clk, rst : clock, synchronous active-high reset (all stages -> BLUE)
//   i_idx    : colour index 1..6
//   o_rgb    : {R,G,B} word, LUT_LAT cycles after i_idx
module colour_lut
  import light_seq_pkg::*;
#(
  parameter int unsigned CW      = 8,
  parameter int unsigned LUT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [3*CW-1:0]   o_rgb
);

  logic [3*CW-1:0] w_rgb;
  logic [3*CW-1:0] w_blue;
  logic [3*CW-1:0] r_pipe [LUT_LAT];

  assign w_rgb  = (3*CW)'(idx_to_rgb(i_idx, CW));
  assign w_blue = (3*CW)'(blue_word(CW));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < LUT_LAT; k++) r_pipe[k] <= w_blue;
    end else begin
      r_pipe[0] <= w_rgb;
      for (int unsigned k = 1; k < LUT_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_rgb = r_pipe[LUT_LAT-1];

endmodule

// File: rtl/light_sequencer_multi.sv
// Multi-channel light sequencer.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of light_sequencer_multi_if (sel/mode/button/presc in,
//          light/wrap out)
// Holds the AUTO prescaler, per-channel index/edge/wrap registers, one
// colour_lut per channel and the final white-forcing mux.
module light_sequencer_multi
  import light_seq_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 8,
  parameter int unsigned NSTATES = 6,
  parameter int unsigned LUT_LAT = 2,
  parameter int unsigned PRESC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  light_sequencer_multi_if.slave   bus
);

  mode_e                w_mode;
  logic                 w_tick;
  logic [NCH-1:0]       w_adv;
  logic [NCH*3*CW-1:0]  w_lut;

  logic [PRESC_W-1:0]   r_cnt;
  logic [IDX_W-1:0]     r_idx [NCH];
  logic [NCH-1:0]       r_btn_q;
  logic [NCH-1:0]       r_wrap;

  assign w_mode = mode_e'(bus.mode);
  assign w_tick = (w_mode == AUTO) && (r_cnt == bus.presc);

  // Count is held at zero outside AUTO so re-entering AUTO starts a full period.
  always_ff @(posedge clk) begin
    if (rst || (w_mode != AUTO) || w_tick) r_cnt <= '0;
    else                                   r_cnt <= r_cnt + 1'b1;
  end

  always_comb begin
    w_adv = '0;
    case (w_mode)
      HOLD_RUN: w_adv = bus.button;
      AUTO:     w_adv = {NCH{w_tick}};
      STEP:     w_adv = bus.button & ~r_btn_q;
      FREEZE:   w_adv = '0;
      default:  w_adv = '0;
    endcase
  end

  // Edge register tracks button in every mode, so STEP entered with a held
  // button sees no rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) r_idx[i] <= IDX_BLUE;
      r_btn_q <= '0;
      r_wrap  <= '0;
    end else begin
      r_btn_q <= bus.button;
      for (int unsigned i = 0; i < NCH; i++) begin
        r_wrap[i] <= 1'b0;
        if (w_adv[i]) begin
          if (r_idx[i] == IDX_W'(NSTATES)) begin
            r_idx[i]  <= IDX_BLUE;
            r_wrap[i] <= 1'b1;
          end else begin
            r_idx[i] <= r_idx[i] + 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    colour_lut #(.CW(CW), .LUT_LAT(LUT_LAT)) u_lut (
      .clk   (clk),
      .rst   (rst),
      .i_idx (r_idx[g]),
      .o_rgb (w_lut[g*3*CW +: 3*CW])
    );
  end

  assign bus.light = bus.sel ? w_lut : '1;
  assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_light_sequencer_multi.sv
module tb_light_sequencer_multi;

  localparam int NCH     = 2;
  localparam int CW      = 8;
  localparam int NSTATES = 6;
  localparam int LUT_LAT = 2;
  localparam int PRESC_W = 16;
  localparam int W       = NCH * 3 * CW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  light_sequencer_multi_if #(.NCH(NCH), .CW(CW), .PRESC_W(PRESC_W)) bus ();

  light_sequencer_multi #(
    .NCH(NCH), .CW(CW), .NSTATES(NSTATES), .LUT_LAT(LUT_LAT), .PRESC_W(PRESC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: colour index per channel, prescaler count, previous
  // button, wrap flags and a LUT_LAT-deep delay line of displayed colours.
  int              m_idx  [NCH];
  logic [15:0]     m_cnt;
  logic [NCH-1:0]  m_prev;
  logic [NCH-1:0]  m_wrap;
  logic [23:0]     m_dly  [NCH][LUT_LAT];

  function automatic logic [23:0] colour_of(int idx);
    case (idx)
      1: return 24'h0000FF;
      2: return 24'h00FF00;
      3: return 24'h00FFFF;
      4: return 24'hFF0000;
      5: return 24'hFF00FF;
      6: return 24'hFFFF00;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_light();
    logic [W-1:0] v;
    if (!bus.sel) return {W{1'b1}};
    for (int c = 0; c < NCH; c++) v[c*24 +: 24] = m_dly[c][LUT_LAT-1];
    return v;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tick;
    bit adv;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_idx[c] = 1;
        for (int k = 0; k < LUT_LAT; k++) m_dly[c][k] = 24'h0000FF;
      end
      m_cnt = '0; m_prev = '0; m_wrap = '0;
    end else begin
      tick = (bus.mode == 2'b01) && (m_cnt == bus.presc);
      if (bus.mode != 2'b01 || tick) m_cnt = '0;
      else m_cnt = m_cnt + 16'd1;
      for (int c = 0; c < NCH; c++) begin
        case (bus.mode)
          2'b00:   adv = bus.button[c];
          2'b01:   adv = tick;
          2'b10:   adv = bus.button[c] && !m_prev[c];
          default: adv = 1'b0;
        endcase
        for (int k = LUT_LAT - 1; k > 0; k--) m_dly[c][k] = m_dly[c][k-1];
        m_dly[c][0] = colour_of(m_idx[c]);
        m_wrap[c] = 1'b0;
        if (adv) begin
          if (m_idx[c] == NSTATES) begin
            m_idx[c] = 1;
            m_wrap[c] = 1'b1;
          end else begin
            m_idx[c] = m_idx[c] + 1;
          end
        end
      end
      m_prev = bus.button;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("light", bus.light, exp_light());
    check("wrap", W'(bus.wrap), W'(m_wrap));
  endtask

  task automatic drive(input logic r, input logic s, input logic [1:0] m,
                       input logic [NCH-1:0] b, input logic [PRESC_W-1:0] p);
    rst = r; bus.sel = s; bus.mode = m; bus.button = b; bus.presc = p;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    logic [W-1:0] all_blue;
    logic [W-1:0] tmp;
    int guard;
    all_blue = {24'h0000FF, 24'h0000FF};

    // 1: reset, then idle
    drive(1, 1, 2'b00, 2'b00, 16'd0);
    run(3);
    check("reset_light", bus.light, all_blue);
    drive(0, 1, 2'b00, 2'b00, 16'd0);
    run(5);
    check("idle_light", bus.light, all_blue);

    // 2: HOLD_RUN on ch0 for a full revolution
    drive(0, 1, 2'b00, 2'b01, 16'd0);
    run(6);
    drive(0, 1, 2'b00, 2'b00, 16'd0);
    run(3);
    check("hold_full_cycle", bus.light, all_blue);

    // 3: STEP, button held several cycles -> single advance on ch1
    drive(0, 1, 2'b10, 2'b10, 16'd0);
    run(4);
    drive(0, 1, 2'b10, 2'b00, 16'd0);
    run(3);
    tmp = bus.light;
    check("step_once", W'(tmp[47:24]), W'(24'h00FF00));
    // enter STEP with button already held
    drive(0, 1, 2'b00, 2'b10, 16'd0);
    run(1);
    drive(0, 1, 2'b10, 2'b10, 16'd0);
    run(4);
    drive(0, 1, 2'b10, 2'b00, 16'd0);
    run(3);

    // 4: AUTO with presc=3, then presc=0, then FREEZE
    drive(0, 1, 2'b01, 2'b11, 16'd3);
    run(12);
    drive(0, 1, 2'b01, 2'b11, 16'd0);
    run(5);
    drive(0, 1, 2'b11, 2'b11, 16'd0);
    run(4);
    drive(0, 1, 2'b01, 2'b00, 16'd2);
    run(4);

    // 5: sel=0 during AUTO is immediate; sequencing continues underneath
    drive(0, 0, 2'b01, 2'b00, 16'd1);
    #1;
    check("sel0_immediate", bus.light, {W{1'b1}});
    run(10);
    bus.sel = 1'b1;
    #1;
    check("sel1_resume", bus.light, exp_light());
    run(3);

    // 6: reset with sel=0, then reset on a wrap edge
    drive(1, 0, 2'b01, 2'b00, 16'd0);
    run(1);
    check("rst_sel0", bus.light, {W{1'b1}});
    drive(0, 1, 2'b00, 2'b00, 16'd0);
    #1;
    check("rst_then_sel1", bus.light, all_blue);
    drive(0, 1, 2'b00, 2'b01, 16'd0);
    guard = 0;
    while (m_idx[0] != NSTATES && guard < 20) begin
      step();
      guard++;
    end
    check("reach_last_idx", W'(guard < 20), W'(1));
    drive(1, 1, 2'b00, 2'b01, 16'd0);
    run(1);
    check("wrap_under_rst", W'(bus.wrap), W'(0));
    drive(0, 1, 2'b00, 2'b00, 16'd0);
    run(3);

    // Randomised phase
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.sel = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) bus.mode = 2'($urandom_range(0, 3));
      bus.button = NCH'($urandom);
      if ($urandom_range(0, 15) == 0) bus.presc = PRESC_W'($urandom_range(0, 3));
      #1;
      check("comb_light", bus.light, exp_light());
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
